// File: rtl/periph_loopback_buf_if.sv
// Signal bundle between a reconfigurable peripheral slot and the peripheral
// that occupies it: config, I/O pins, TX FIFO read side, RX FIFO write side.
interface periph_loopback_buf_if #(
  parameter int DATA_W = 30,
  parameter int IN_W   = 8,
  parameter int OUT_W  = 8,
  parameter int TRI_W  = 4
);
  logic [1:0]        cfg_mode;
  logic [IN_W-1:0]   in;
  logic [OUT_W-1:0]  out;
  logic [TRI_W-1:0]  tristate;
  logic [DATA_W-1:0] tx_data;
  logic              tx_empty;
  logic              tx_rden;
  logic [DATA_W-1:0] rx_data;
  logic              rx_wren;
  logic              rx_full;
  logic              idle;

  // Slot side: owns the FIFOs, the pins and the mode configuration.
  modport master (
    output cfg_mode, in, tx_data, tx_empty, rx_full,
    input  out, tristate, tx_rden, rx_data, rx_wren, idle
  );

  // Peripheral side.
  modport slave (
    input  cfg_mode, in, tx_data, tx_empty, rx_full,
    output out, tristate, tx_rden, rx_data, rx_wren, idle
  );
endinterface

// File: rtl/periph_loopback_buf.sv
// Buffered loopback test peripheral. Drains the slot TX FIFO (1-cycle read
// latency), transforms each word by mode and queues it into a small elastic
// buffer that feeds the slot RX FIFO. Reads are only issued when a buffer
// slot is guaranteed for the returning word, so nothing is ever dropped.
module periph_loopback_buf #(
  parameter int DATA_W = 30,
  parameter int DEPTH  = 4,
  parameter int IN_W   = 8,
  parameter int OUT_W  = 8,
  parameter int TRI_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  periph_loopback_buf_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    MODE_LOOP = 2'd0,
    MODE_INV  = 2'd1,
    MODE_PAT  = 2'd2,
    MODE_PIN  = 2'd3
  } mode_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  occupancy;
  logic              inflight;
  mode_t             mode_r;
  mode_t             cfg_m;
  logic [DATA_W-1:0] pat_cnt;
  logic [OUT_W-1:0]  out_r;
  logic [TRI_W-1:0]  tri_r;
  logic [DATA_W-1:0] push_word;
  logic              push;
  logic              pop;
  logic              rden;
  logic              idle;

  // Word transform applied to a returning TX word; in pin mode the buffered
  // word is the sampled input pins, zero-extended.
  function automatic logic [DATA_W-1:0] xform(input mode_t             m,
                                              input logic [DATA_W-1:0] w,
                                              input logic [DATA_W-1:0] pat,
                                              input logic [IN_W-1:0]   pins);
    logic [DATA_W-1:0] r;
    r = '0;
    case (m)
      MODE_LOOP: r = w;
      MODE_INV:  r = ~w;
      MODE_PAT:  r = pat;
      default:   r[IN_W-1:0] = pins;
    endcase
    return r;
  endfunction

  assign cfg_m     = mode_t'(bus.cfg_mode);
  // Slots already claimed: words sitting in the buffer plus the one whose
  // read was strobed last cycle and is returning now.
  assign occupancy = count + CNT_W'(inflight);
  // rst_n gates the strobe so no read is issued while reset is held.
  assign rden      = rst_n && !bus.tx_empty && (occupancy < CNT_W'(DEPTH));
  assign push      = inflight;
  assign pop       = (count != '0) && !bus.rx_full;
  assign idle      = bus.tx_empty && !inflight && (count == '0);

  assign bus.tx_rden  = rden;
  assign bus.rx_wren  = pop;
  assign bus.rx_data  = mem[rd_ptr];
  assign bus.idle     = idle;
  assign bus.out      = out_r;
  assign bus.tristate = tri_r;

  // Transform the word returning from the TX FIFO this cycle.
  always_comb begin
    push_word = xform(mode_r, bus.tx_data, pat_cnt, bus.in);
  end

  // Read tracking, buffer pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= rden;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Buffer storage; data only, never reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  // Mode register (loads only while idle), pattern counter and pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r  <= MODE_LOOP;
      pat_cnt <= '0;
      out_r   <= '0;
      tri_r   <= '1;
    end else if (idle) begin
      mode_r <= cfg_m;
      if (cfg_m != mode_r) begin
        if (cfg_m == MODE_PAT) pat_cnt <= '0;
        if (cfg_m != MODE_PIN) begin
          out_r <= '0;
          tri_r <= '1;
        end
      end
    end else if (push) begin
      if (mode_r == MODE_PAT) pat_cnt <= pat_cnt + DATA_W'(1);
      if (mode_r == MODE_PIN) begin
        out_r <= bus.tx_data[OUT_W-1:0];
        tri_r <= bus.tx_data[OUT_W +: TRI_W];
      end
    end
  end
endmodule

// File: tb/tb_periph_loopback_buf.sv
// Bench for periph_loopback_buf: a word-level queue model of the TX FIFO,
// the elastic buffer and the mode/pin state, plus a narrow instance for the
// pattern-counter wrap.
module tb_periph_loopback_buf;
  localparam int DATA_W = 30;
  localparam int DEPTH  = 4;
  localparam int IN_W   = 8;
  localparam int OUT_W  = 8;
  localparam int TRI_W  = 4;
  localparam int S_W    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  periph_loopback_buf_if #(.DATA_W(DATA_W), .IN_W(IN_W), .OUT_W(OUT_W), .TRI_W(TRI_W)) bus ();
  periph_loopback_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W), .TRI_W(TRI_W))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  periph_loopback_buf_if #(.DATA_W(S_W), .IN_W(2), .OUT_W(2), .TRI_W(2)) bus_s ();
  periph_loopback_buf #(.DATA_W(S_W), .DEPTH(4), .IN_W(2), .OUT_W(2), .TRI_W(2))
    dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  logic [DATA_W-1:0] tx_q[$];
  logic [DATA_W-1:0] buf_q[$];
  logic [DATA_W-1:0] hold_q[$];
  bit                ret_v;
  logic [DATA_W-1:0] ret_w;
  logic [1:0]        mode_m;
  logic [DATA_W-1:0] pat_m;
  logic [OUT_W-1:0]  out_m;
  logic [TRI_W-1:0]  tri_m;
  int                cyc, rd_seen, wr_seen, first_rd, first_wr;
  logic [DATA_W-1:0] last_rx;
  logic [S_W-1:0]    rx_s[$];
  int                left_s;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_idle();
    return (tx_q.size() == 0) && !ret_v && (buf_q.size() == 0);
  endfunction

  // One clock cycle: entered just after a negedge with inputs applied.
  task automatic cycle();
    bit                e_rd, e_wr, e_idle;
    logic [DATA_W-1:0] w;
    bus.tx_empty = (tx_q.size() == 0);
    #1;
    e_rd   = rst_n && (tx_q.size() != 0) && ((buf_q.size() + int'(ret_v)) < DEPTH);
    e_wr   = rst_n && (buf_q.size() != 0) && !bus.rx_full;
    e_idle = model_idle();
    chk("tx_rden", bus.tx_rden, e_rd);
    chk("rx_wren", bus.rx_wren, e_wr);
    chk("idle", bus.idle, e_idle);
    chk("out", bus.out, out_m);
    chk("tristate", bus.tristate, tri_m);
    if (buf_q.size() != 0) chk("rx_data", bus.rx_data, buf_q[0]);
    if (bus.tx_rden === 1'b1) begin
      rd_seen++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (bus.rx_wren === 1'b1) begin
      wr_seen++;
      last_rx = bus.rx_data;
      if (first_wr < 0) first_wr = cyc;
    end
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      if (e_idle) begin
        if (bus.cfg_mode != mode_m) begin
          if (bus.cfg_mode == 2'd2) pat_m = '0;
          if (bus.cfg_mode != 2'd3) begin
            out_m = '0;
            tri_m = '1;
          end
        end
        mode_m = bus.cfg_mode;
      end
      if (e_wr) void'(buf_q.pop_front());
      if (ret_v) begin
        w = '0;
        case (mode_m)
          2'd0: w = ret_w;
          2'd1: w = ~ret_w;
          2'd2: begin
            w     = pat_m;
            pat_m = pat_m + DATA_W'(1);
          end
          default: begin
            out_m         = ret_w[OUT_W-1:0];
            tri_m         = ret_w[OUT_W +: TRI_W];
            w[IN_W-1:0]   = bus.in;
          end
        endcase
        buf_q.push_back(w);
      end
      ret_v = e_rd;
      if (e_rd) ret_w = tx_q.pop_front();
    end
    @(negedge clk);
    bus.tx_data = ret_v ? ret_w : DATA_W'($urandom());
  endtask

  task automatic run_until_idle(input int budget, input int full_pct, input bit rnd);
    int n;
    n = 0;
    while (!model_idle() && n < budget) begin
      bus.rx_full = ($urandom_range(99) < full_pct);
      if (rnd) begin
        bus.in = IN_W'($urandom());
        if ($urandom_range(9) == 0) bus.cfg_mode = 2'($urandom_range(3));
      end
      cycle();
      n++;
    end
    if (!model_idle()) chk("drain_timeout", 0, 1);
    bus.rx_full = 1'b0;
  endtask

  // Narrow instance: one cycle per iteration, collecting RX words.
  task automatic run_s(input int n);
    for (int k = 0; k < n; k++) begin
      bus_s.tx_empty = (left_s == 0);
      #1;
      if (bus_s.rx_wren === 1'b1) rx_s.push_back(bus_s.rx_data);
      if (bus_s.tx_rden === 1'b1) left_s--;
      @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.cfg_mode = 2'd0; bus.in = '0; bus.tx_data = '0; bus.tx_empty = 1'b1; bus.rx_full = 1'b0;
    bus_s.cfg_mode = 2'd0; bus_s.in = '0; bus_s.tx_data = '0; bus_s.tx_empty = 1'b1; bus_s.rx_full = 1'b0;
    mode_m = 2'd0; pat_m = '0; out_m = '0; tri_m = '1; ret_v = 1'b0; ret_w = '0;
    cyc = 0; rd_seen = 0; wr_seen = 0; first_rd = -1; first_wr = -1; last_rx = '0; left_s = 0;

    // Reset state
    @(negedge clk);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // Mode 0 stream 1..8
    first_rd = -1; first_wr = -1;
    for (int i = 1; i <= 8; i++) tx_q.push_back(DATA_W'(i));
    run_until_idle(60, 0, 1'b0);
    chk("m0_first_latency", first_wr - first_rd, 2);
    chk("m0_last_word", last_rx, 8);

    // Backpressure: 10 words against a full RX FIFO
    rd_seen = 0; wr_seen = 0;
    bus.rx_full = 1'b1;
    for (int i = 0; i < 10; i++) tx_q.push_back(DATA_W'(32'h100 + i));
    repeat (8) cycle();
    chk("bp_rden_pulses", rd_seen, 4);
    chk("bp_rden_held", bus.tx_rden, 0);
    run_until_idle(60, 0, 1'b0);
    chk("bp_words_out", wr_seen, 10);
    chk("bp_last_word", last_rx, 32'h109);

    // Mode request while busy is ignored; takes effect once idle
    for (int i = 0; i < 4; i++) tx_q.push_back(DATA_W'(32'h0ABCDE0 + i));
    cycle();
    cycle();
    bus.cfg_mode = 2'd1;
    run_until_idle(40, 0, 1'b0);
    chk("busy_mode_ignored", last_rx, 32'h0ABCDE3);
    cycle();
    tx_q.push_back('0);
    run_until_idle(20, 0, 1'b0);
    chk("m1_invert_zero", last_rx, 32'h3FFFFFFF);

    // Randomized phases with random backpressure, pins and mode requests
    for (int p = 0; p < 16; p++) begin
      bus.cfg_mode = 2'($urandom_range(3));
      cycle();
      repeat ($urandom_range(1, 12)) tx_q.push_back(DATA_W'($urandom()));
      run_until_idle(300, $urandom_range(0, 60), 1'b1);
    end

    // Pin mode
    bus.cfg_mode = 2'd3;
    bus.in = 8'hA5;
    cycle();
    tx_q.push_back(DATA_W'(32'h00000F3C));
    run_until_idle(20, 0, 1'b0);
    chk("m3_out", bus.out, 8'h3C);
    chk("m3_tristate", bus.tristate, 4'hF);
    chk("m3_rx_word", last_rx, 32'hA5);
    bus.cfg_mode = 2'd0;
    cycle();
    chk("m0_out_forced", bus.out, 0);
    chk("m0_tri_forced", bus.tristate, 4'hF);

    // Asynchronous reset with 3 words buffered
    bus.cfg_mode = 2'd3;
    cycle();
    bus.rx_full = 1'b1;
    tx_q.push_back(DATA_W'(32'h255));
    tx_q.push_back(DATA_W'(32'h1AA));
    tx_q.push_back(DATA_W'(32'h3C3));
    repeat (5) cycle();
    chk("rst_pre_out", bus.out, 8'hC3);
    tx_q.push_back(DATA_W'(32'h111));
    tx_q.push_back(DATA_W'(32'h222));
    bus.tx_empty = 1'b0;
    bus.rx_full  = 1'b0;
    #1;
    chk("rst_pre_wren", bus.rx_wren, 1);
    chk("rst_pre_rden", bus.tx_rden, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_rx_wren", bus.rx_wren, 0);
    chk("rst_tx_rden", bus.tx_rden, 0);
    chk("rst_out", bus.out, 0);
    chk("rst_tristate", bus.tristate, 4'hF);
    chk("rst_idle_busy_tx", bus.idle, 0);
    buf_q.delete();
    ret_v = 1'b0; mode_m = 2'd0; pat_m = '0; out_m = '0; tri_m = '1;
    @(negedge clk);
    bus.tx_data = DATA_W'($urandom());
    cycle();
    hold_q = tx_q;
    tx_q.delete();
    cycle();
    tx_q = hold_q;
    rst_n = 1'b1;
    run_until_idle(40, 0, 1'b0);
    chk("rst_after_last", last_rx, 32'h222);

    // Pattern wrap on the 4-bit instance
    bus_s.cfg_mode = 2'd2;
    run_s(3);
    rx_s.delete();
    left_s = 18;
    run_s(40);
    chk("pat_count", rx_s.size(), 18);
    for (int i = 0; i < 18 && i < rx_s.size(); i++) chk("pat_wrap", rx_s[i], i % 16);
    bus_s.cfg_mode = 2'd0;
    bus_s.tx_data  = 4'h9;
    run_s(3);
    rx_s.delete();
    left_s = 1;
    run_s(6);
    chk("pat_leave_n", rx_s.size(), 1);
    if (rx_s.size() > 0) chk("pat_leave_word", rx_s[0], 4'h9);
    bus_s.cfg_mode = 2'd2;
    run_s(3);
    rx_s.delete();
    left_s = 1;
    run_s(6);
    chk("pat_reenter_n", rx_s.size(), 1);
    if (rx_s.size() > 0) chk("pat_reenter_word", rx_s[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
